map: RTL and testbench
======================

Name: map

Overview:
- Static playfield renderer for the Donkey Kong VGA controller.
- Each cycle it receives the current raster position (hcount, vcount) and reports whether that pixel belongs to a girder or ladder tile.
- Sits between the VGA sync counter and the colour mux; tile_draw selects the girder/ladder colour.
- The map is fixed: a hard-coded layout of 8x8-pixel tiles on a 640x480 screen.

Parameters:
- H_ACTIVE, 640, visible pixels per line; hcount >= H_ACTIVE never draws.
- V_ACTIVE, 480, visible lines; vcount >= V_ACTIVE never draws.

Ports:
- clk  input  1  pixel clock.
- reset  input  1  asynchronous, active-low reset.
- hcount  input  10  current pixel column, 0 = left.
- vcount  input  10  current pixel row, 0 = top.
- bounds_draw  input  1  drawing enable from the sync/bounds logic; 0 forces no draw.
- tile_draw  output  1  1 = pixel is part of a girder or ladder.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: tile_draw = 0 immediately while reset is low.
- Output: tile_draw is registered, 1-cycle latency. tile_draw(n+1) = bounds_draw(n) AND visible(n) AND (girder_hit(n) OR ladder_hit(n)).
- visible: hcount < 640 AND vcount < 480.
- Tile coordinates:
  - Local column c = hcount[2:0], local row r = vcount[2:0].
  - Bitmap bit index 0 = leftmost column (c = 0).
- Girder platforms. Each spans rows y_top..y_top+7 and columns x_start..x_end inclusive:
  - P0: y 448, x 16..623
  - P1: y 384, x 16..575
  - P2: y 320, x 64..623
  - P3: y 256, x 16..575
  - P4: y 192, x 64..623
  - P5: y 128, x 16..575
  - P6: y 80, x 200..439
- Girder bitmap, rows r0..r7, columns c0..c7:
  - r0 00000000
  - r1 11111111
  - r2 11111111
  - r3 10011001
  - r4 01110000
  - r5 00001110
  - r6 11111111
  - r7 00000000
- girder_hit = pixel lies inside any platform AND bitmap[r][c] = 1.
- Ladders. Each is 8 pixels wide, columns x..x+7, rows y0..y1 inclusive:
  - L0: x 560, y 392..447
  - L1: x 96, y 328..383
  - L2: x 520, y 264..319
  - L3: x 104, y 200..255
  - L4: x 560, y 136..191
  - L5: x 304, y 88..127
- Ladder bitmap: rails at c = 0 and c = 7 on every row; rungs (all columns) on r = 0 and r = 4; all other pixels 0.
- ladder_hit = pixel lies inside any ladder AND ladder bitmap = 1.
- Regions never overlap. If they ever did, the result is the OR of both hits.
- All range compares are unsigned 10-bit, with inclusive bounds.
- No state besides the output register. Reset asserted mid-frame clears the output; the next valid cycle after release resumes normal output.

Test Plan:
- Reset low with any inputs -> tile_draw = 0 immediately. Release reset, apply (150,450) with bounds_draw = 1 -> tile_draw = 1 on the following clock.
- P0 row r2, bounds_draw = 1 -> tile_draw = 1 one cycle later at each of hcount = 150, 160, 200, 208, 250 with vcount = 450.
- P0 row r4 at vcount = 452, bounds_draw = 1:
  - hcount = 150 and 160 -> tile_draw = 0.
  - hcount = 153, 154, 155 -> tile_draw = 1.
- (150,450) with bounds_draw = 0 -> tile_draw = 0.
- Out-of-range and empty-area pixels -> tile_draw = 0:
  - (700,450) and (150,500): outside the visible screen.
  - (8,450): left of P0.
  - (150,440): above P0.
- Ladder L0 at vcount = 394 (r2):
  - hcount = 560 and 567 -> tile_draw = 1 (rails).
  - hcount = 563 -> tile_draw = 0.
  - (563,396), i.e. rung row r4 -> tile_draw = 1.

Source files
------------

// File: rtl/map.sv
// Static Donkey Kong playfield: flags raster pixels that fall on a girder or ladder tile.
// Output is registered with one cycle of latency behind hcount/vcount/bounds_draw.
module map #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       bounds_draw,
  output logic       tile_draw
);

  typedef logic [9:0] coord_t;

  localparam int     N_PLAT = 7;
  localparam int     N_LAD  = 6;
  localparam coord_t H_LIM  = 10'(H_ACTIVE);
  localparam coord_t V_LIM  = 10'(V_ACTIVE);

  localparam coord_t PLAT_Y  [N_PLAT] = '{10'd448, 10'd384, 10'd320, 10'd256, 10'd192, 10'd128, 10'd80};
  localparam coord_t PLAT_X0 [N_PLAT] = '{10'd16,  10'd16,  10'd64,  10'd16,  10'd64,  10'd16,  10'd200};
  localparam coord_t PLAT_X1 [N_PLAT] = '{10'd623, 10'd575, 10'd623, 10'd575, 10'd623, 10'd575, 10'd439};

  localparam coord_t LAD_X  [N_LAD] = '{10'd560, 10'd96,  10'd520, 10'd104, 10'd560, 10'd304};
  localparam coord_t LAD_Y0 [N_LAD] = '{10'd392, 10'd328, 10'd264, 10'd200, 10'd136, 10'd88};
  localparam coord_t LAD_Y1 [N_LAD] = '{10'd447, 10'd383, 10'd319, 10'd255, 10'd191, 10'd127};

  // Bit c of a row word is tile column c (bit 0 = leftmost pixel).
  function automatic logic [7:0] girder_row(input logic [2:0] r);
    case (r)
      3'd1, 3'd2, 3'd6: girder_row = 8'hFF;
      3'd3:             girder_row = 8'h99;
      3'd4:             girder_row = 8'h0E;
      3'd5:             girder_row = 8'h70;
      default:          girder_row = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] ladder_row(input logic [2:0] r);
    if (r == 3'd0 || r == 3'd4) ladder_row = 8'hFF;
    else                        ladder_row = 8'h81;
  endfunction

  logic [2:0] col;
  logic [2:0] row;
  logic [7:0] girder_bits;
  logic [7:0] ladder_bits;
  logic       visible;
  logic       in_plat;
  logic       in_lad;
  logic       girder_hit;
  logic       ladder_hit;
  logic       draw_next;

  assign col         = hcount[2:0];
  assign row         = vcount[2:0];
  assign girder_bits = girder_row(row);
  assign ladder_bits = ladder_row(row);
  assign visible     = (hcount < H_LIM) && (vcount < V_LIM);

  always_comb begin
    in_plat = 1'b0;
    for (int i = 0; i < N_PLAT; i++) begin
      if (vcount >= PLAT_Y[i] && vcount <= PLAT_Y[i] + 10'd7 &&
          hcount >= PLAT_X0[i] && hcount <= PLAT_X1[i])
        in_plat = 1'b1;
    end
  end

  always_comb begin
    in_lad = 1'b0;
    for (int i = 0; i < N_LAD; i++) begin
      if (hcount >= LAD_X[i] && hcount <= LAD_X[i] + 10'd7 &&
          vcount >= LAD_Y0[i] && vcount <= LAD_Y1[i])
        in_lad = 1'b1;
    end
  end

  assign girder_hit = in_plat & girder_bits[col];
  assign ladder_hit = in_lad & ladder_bits[col];
  assign draw_next  = bounds_draw & visible & (girder_hit | ladder_hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tile_draw <= 1'b0;
    else        tile_draw <= draw_next;
  end

endmodule

// File: tb/tb_map.sv
// Bench for map: directed literal checks plus randomized raster positions
// compared every cycle against a table-driven model of the playfield.
module tb_map;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] hcount = '0;
  logic [9:0] vcount = '0;
  logic       bounds_draw = 1'b0;
  logic       tile_draw;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;
  bit exp_draw = 1'b0;

  map dut (
    .clk(clk),
    .reset(reset),
    .hcount(hcount),
    .vcount(vcount),
    .bounds_draw(bounds_draw),
    .tile_draw(tile_draw)
  );

  always #5 clk = ~clk;

  string gbm [0:7] = '{"00000000", "11111111", "11111111", "10011001",
                       "01110000", "00001110", "11111111", "00000000"};
  int py  [0:6] = '{448, 384, 320, 256, 192, 128, 80};
  int px0 [0:6] = '{16, 16, 64, 16, 64, 16, 200};
  int px1 [0:6] = '{623, 575, 623, 575, 623, 575, 439};
  int lx  [0:5] = '{560, 96, 520, 104, 560, 304};
  int ly0 [0:5] = '{392, 328, 264, 200, 136, 88};
  int ly1 [0:5] = '{447, 383, 319, 255, 191, 127};

  function automatic bit model(input int h, input int v, input bit b);
    bit hit = 0;
    int r = v % 8;
    int c = h % 8;
    string s;
    if (!b || h >= 640 || v >= 480) return 0;
    for (int i = 0; i < 7; i++) begin
      if (v >= py[i] && v <= py[i] + 7 && h >= px0[i] && h <= px1[i]) begin
        s = gbm[v - py[i]];
        if (s[c] == "1") hit = 1;
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (h >= lx[i] && h <= lx[i] + 7 && v >= ly0[i] && v <= ly1[i])
        if (r == 0 || r == 4 || c == 0 || c == 7) hit = 1;
    end
    return hit;
  endfunction

  // Model of what tile_draw must hold after each clock.
  always @(posedge clk or negedge reset) begin
    if (!reset) exp_draw <= 1'b0;
    else        exp_draw <= model(int'(hcount), int'(vcount), bounds_draw);
  end

  always @(negedge clk) begin
    if (model_on) begin
      checks++;
      if (tile_draw !== exp_draw) begin
        errors++;
        $display("FAIL model h=%0d v=%0d got=%b want=%b", hcount, vcount, tile_draw, exp_draw);
      end
    end
  end

  task automatic lit(input string name, input bit want);
    checks++;
    if (tile_draw !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, tile_draw, want);
    end
  endtask

  // Apply a pixel, clock it through, then check the registered output.
  task automatic pix(input int h, input int v, input bit b, input bit want, input string name);
    @(posedge clk); #1;
    hcount = 10'(h); vcount = 10'(v); bounds_draw = b;
    @(posedge clk); #1;
    lit(name, want);
  endtask

  initial begin
    hcount = 10'd150; vcount = 10'd450; bounds_draw = 1'b1;
    repeat (3) @(posedge clk);
    #1 lit("reset_hold", 1'b0);
    #2 reset = 1'b1;
    model_on = 1'b1;

    pix(150, 450, 1, 1, "first_after_reset");
    pix(150, 450, 1, 1, "p0_r2_150");
    pix(160, 450, 1, 1, "p0_r2_160");
    pix(200, 450, 1, 1, "p0_r2_200");
    pix(208, 450, 1, 1, "p0_r2_208");
    pix(250, 450, 1, 1, "p0_r2_250");
    pix(150, 452, 1, 0, "p0_r4_150");
    pix(160, 452, 1, 0, "p0_r4_160");
    pix(153, 452, 1, 1, "p0_r4_153");
    pix(154, 452, 1, 1, "p0_r4_154");
    pix(155, 452, 1, 1, "p0_r4_155");
    pix(150, 450, 0, 0, "bounds_off");
    pix(700, 450, 1, 0, "h_offscreen");
    pix(150, 500, 1, 0, "v_offscreen");
    pix(8, 450, 1, 0, "left_of_p0");
    pix(150, 440, 1, 0, "above_p0");
    pix(560, 394, 1, 1, "l0_rail_left");
    pix(567, 394, 1, 1, "l0_rail_right");
    pix(563, 394, 1, 0, "l0_gap");
    pix(563, 396, 1, 1, "l0_rung");
    pix(16, 448 + 3, 1, 1, "p0_left_edge");
    pix(623, 451, 1, 1, "p0_right_edge");
    pix(624, 451, 1, 0, "p0_past_right");
    pix(200, 81, 1, 1, "p6_left_edge");
    pix(304, 88, 1, 1, "l5_top_rung");

    // Mid-frame reset clears the output at once and normal output resumes after release.
    pix(150, 450, 1, 1, "pre_midreset");
    #2 reset = 1'b0;
    #1 lit("midreset_immediate", 1'b0);
    @(posedge clk); #1 lit("midreset_held", 1'b0);
    #2 reset = 1'b1;
    pix(150, 450, 1, 1, "after_midreset");

    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) begin
        hcount = 10'($urandom_range(0, 1023));
        vcount = 10'($urandom_range(0, 1023));
      end else begin
        hcount = 10'($urandom_range(0, 660));
        vcount = 10'($urandom_range(70, 490));
      end
      bounds_draw = ($urandom_range(0, 9) != 0);
    end
    @(posedge clk); #1;
    model_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
